// File: rtl/memory_bank_if.sv
// memory_bank_if
//   Bus bundle between a requester (master) and the memory_bank (slave).
//   Write port : wr_valid / wr_ready handshake with wr_addr, wr_data.
//   Clear port : clr_start request pulse, clr_busy status.
//   Read port  : rd_en, rd_addr in; rd_data, rd_valid out (1-cycle latency).
//   mem_flat   : flattened view of every entry, entry i at [i*WIDTH +: WIDTH].
interface memory_bank_if #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 20,
  parameter int AW    = 6
);
  logic                   wr_valid;
  logic                   wr_ready;
  logic [AW-1:0]          wr_addr;
  logic [WIDTH-1:0]       wr_data;
  logic                   clr_start;
  logic                   clr_busy;
  logic                   rd_en;
  logic [AW-1:0]          rd_addr;
  logic [WIDTH-1:0]       rd_data;
  logic                   rd_valid;
  logic [DEPTH*WIDTH-1:0] mem_flat;

  modport master (
    output wr_valid, wr_addr, wr_data, clr_start, rd_en, rd_addr,
    input  wr_ready, clr_busy, rd_data, rd_valid, mem_flat
  );

  modport slave (
    input  wr_valid, wr_addr, wr_data, clr_start, rd_en, rd_addr,
    output wr_ready, clr_busy, rd_data, rd_valid, mem_flat
  );
endinterface

// File: rtl/memory_bank.sv
// memory_bank
//   DEPTH x WIDTH register-based storage feeding the LDC stage through
//   mem_flat. Entries 0..31 are the lower half (addr[5]=0), 32..63 the
//   upper half. Handshaked write, registered read (read-before-write) and
//   a sequential bulk-clear sweep of one entry per cycle.
// Ports:
//   clk     : rising-edge clock
//   rst_n   : asynchronous active-low reset
//   bank_if : memory_bank_if.slave (write, clear, read, mem_flat)
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | writes accepted, waiting for clr_start
// CLEAR  | zeroing entry[r_cnt] each cycle, writes stalled
module memory_bank #(
  parameter int DEPTH = 64,   // must equal 2**AW
  parameter int WIDTH = 20,
  parameter int AW    = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  memory_bank_if.slave bank_if
);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_CLEAR = 1'b1
  } state_t;

  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  state_t           r_state;
  logic [AW-1:0]    r_cnt;
  logic             r_wr_ready;
  logic             r_clr_busy;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rd_data;
  logic             r_rd_valid;
  logic             w_wr_fire;

  assign w_wr_fire = bank_if.wr_valid & r_wr_ready;

  // wr_ready / clr_busy are registered copies of the state decode so they
  // flip on the same edge as the state itself.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_wr_ready <= 1'b1;
      r_clr_busy <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bank_if.clr_start) begin
            r_state    <= S_CLEAR;
            r_cnt      <= '0;
            r_wr_ready <= 1'b0;
            r_clr_busy <= 1'b1;
          end
        end
        S_CLEAR: begin
          // clr_start is ignored here: the sweep is never restarted.
          if (r_cnt == LAST_IDX) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_wr_ready <= 1'b1;
            r_clr_busy <= 1'b0;
          end else begin
            r_cnt <= r_cnt + AW'(1);
          end
        end
        default: begin
          r_state    <= S_IDLE;
          r_cnt      <= '0;
          r_wr_ready <= 1'b1;
          r_clr_busy <= 1'b0;
        end
      endcase
    end
  end

  // A write accepted in the same cycle as clr_start lands at that edge;
  // the sweep starts one edge later and zeroes it in turn.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (r_state == S_CLEAR) begin
      r_mem[r_cnt] <= '0;
    end else if (w_wr_fire) begin
      r_mem[bank_if.wr_addr] <= bank_if.wr_data;
    end
  end

  // Reads sample storage before this edge's write/clear takes effect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= bank_if.rd_en;
      if (bank_if.rd_en) r_rd_data <= r_mem[bank_if.rd_addr];
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_flat
    assign bank_if.mem_flat[g*WIDTH +: WIDTH] = r_mem[g];
  end

  assign bank_if.wr_ready = r_wr_ready;
  assign bank_if.clr_busy = r_clr_busy;
  assign bank_if.rd_data  = r_rd_data;
  assign bank_if.rd_valid = r_rd_valid;

endmodule

// File: doc/memory_bank.md
Name: memory_bank

Overview:
- 64-entry x 20-bit register-based storage bank.
- Sits directly upstream of the constant-load (LDC) stage and drives its flattened memory input bus.
- Entry 0..31 form the lower half selected when address bit 5 = 0; entries 32..63 form the upper half.
- Provides a handshaked write port, a registered read port, and a sequential bulk-clear engine.

Parameters:
- DEPTH, 64, number of entries. Must equal 2**AW.
- WIDTH, 20, bits per entry.
- AW, 6, address width.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous reset, active-low.
- wr_valid  input  1  write request.
- wr_ready  output  1  bank can accept a write this cycle.
- wr_addr  input  AW  write address.
- wr_data  input  WIDTH  write data.
- clr_start  input  1  single-cycle request to zero all entries.
- clr_busy  output  1  clear sequence in progress.
- rd_en  input  1  read request.
- rd_addr  input  AW  read address.
- rd_data  output  WIDTH  registered read data.
- rd_valid  output  1  rd_data updated this cycle.
- mem_flat  output  DEPTH*WIDTH  all entries; entry i occupies bits [i*WIDTH +: WIDTH]; feeds the LDC stage directly.

Behaviour:
- Reset (rst_n low, async):
  - all entries = 0.
  - state = IDLE, clear counter = 0.
  - wr_ready = 1, clr_busy = 0, rd_data = 0, rd_valid = 0.
  - Reset asserted mid-clear or mid-write aborts immediately; the bank returns to the reset values above.
- Write:
  - Accepted on a rising edge when wr_valid && wr_ready.
  - entry[wr_addr] <= wr_data.
  - Visible on mem_flat and to reads from the next cycle.
  - No partial writes.
- Read:
  - 1-cycle latency. When rd_en is high at edge N, rd_data holds entry[rd_addr] sampled before any write at edge N (read-before-write), and rd_valid = 1 for the cycle after edge N.
  - rd_valid deasserts the next cycle if rd_en is low.
  - rd_data holds its last value while rd_en is low.
  - Reads are allowed in every state. A read during clear returns the current stored value, which may already be zeroed.
- State machine, 2 states:
  - IDLE: wr_ready = 1, clr_busy = 0.
    - clr_start = 1 -> go to CLEAR, counter <= 0.
  - CLEAR: wr_ready = 0, clr_busy = 1.
    - Each cycle: entry[counter] <= 0, counter <= counter + 1.
    - When counter = DEPTH-1, that entry is cleared and the state returns to IDLE. The clear takes exactly DEPTH = 64 cycles.
    - clr_start during CLEAR is ignored; no restart or extension.
  - wr_ready and clr_busy are registered state decodes; they change on the edge where the state changes.
- Simultaneous events:
  - wr_valid and clr_start in the same IDLE cycle: the write commits at that edge, and CLEAR begins on the following edge, so the written entry is zeroed during the sweep.
  - wr_valid held during CLEAR: not accepted. The requester must hold the request until wr_ready returns.
- Counter width is AW bits. It does not wrap past DEPTH-1 because the FSM exits at that point.
- mem_flat is the direct, unregistered view of storage: no extra latency beyond the storage registers.

Test Plan:
- Reset then idle: release rst_n and hold 3 cycles -> mem_flat all 0, wr_ready = 1, clr_busy = 0, rd_valid = 0.
- Write/read: write 20'hABCDE to addr 5 and 20'h12345 to addr 37; read addr 37 -> rd_data = 20'h12345 one cycle after rd_en, rd_valid pulses once; mem_flat[37*20 +: 20] = 20'h12345.
- Read-before-write: same-cycle write 20'h00001 and read of addr 5 (holding 20'hABCDE) -> rd_data = 20'hABCDE; a read next cycle returns 20'h00001.
- Bulk clear: fill all 64 entries with index+1, pulse clr_start -> clr_busy high exactly 64 cycles, wr_ready low throughout, writes held during clear not committed, all entries 0 afterwards. A second clr_start at cycle 10 of the clear does not extend it.
- Simultaneous write + clr_start: write 20'hFFFFF to addr 63 in the same cycle as clr_start -> entry 63 reads 20'hFFFFF during early clear cycles and 0 after clr_busy falls.
- Async reset mid-clear: assert rst_n low at clear cycle 20, off-edge -> outputs and entries reset immediately, clr_busy = 0 without waiting for a clock.
